// File: rtl/lwe_decrypt_seq.sv
// Sequential LWE decryption core: streams key/ciphertext beats, accumulates the
// dot product mod 2^CIPHERTEXT_WIDTH and maps it to a plaintext on the last beat.
module lwe_decrypt_seq #(
  parameter int unsigned PLAINTEXT_WIDTH  = 6,
  parameter int unsigned CIPHERTEXT_WIDTH = 10,
  parameter int unsigned DIMENSION        = 1,
  parameter int unsigned LANES            = 1,
  parameter int unsigned ROUND_MODE       = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_sk,
  input  logic [LANES*CIPHERTEXT_WIDTH-1:0]   in_ct,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]          out_result,
  output logic                                out_error
);

  localparam int unsigned CW     = CIPHERTEXT_WIDTH;
  localparam int unsigned PW     = PLAINTEXT_WIDTH;
  localparam int unsigned PROD_W = 2 * CW;
  localparam int unsigned BEATS  = (DIMENSION + 1) / LANES;
  localparam int unsigned BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] HALF = CW'(1) << (CW - PW - 1);

  typedef enum logic {ACC, OUT} state_t;

  state_t          state;
  logic [CW-1:0]   acc;
  logic [BW-1:0]   beat_cnt;

  logic [CW-1:0]     acc_next;
  logic [CW-1:0]     sk_k;
  logic [CW-1:0]     ct_k;
  logic [PROD_W-1:0] prod;
  logic [CW-1:0]     rounded;
  logic [PW-1:0]     result_c;
  logic              last_beat;
  logic              vec_end;
  logic              beat_fire;

  // Multiply-accumulate across lanes; only the low CW bits of each product matter mod 2^CW.
  always_comb begin
    acc_next = acc;
    sk_k     = '0;
    ct_k     = '0;
    prod     = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      sk_k     = in_sk[k*CW +: CW];
      ct_k     = in_ct[k*CW +: CW];
      prod     = PROD_W'(sk_k) * PROD_W'(ct_k);
      acc_next = acc_next + prod[CW-1:0];
    end
  end

  // Round-to-nearest wraps naturally: values just below 2^CW round up to plaintext 0.
  always_comb begin
    rounded = acc_next + HALF;
    if (ROUND_MODE != 0) begin
      result_c = PW'(rounded >> (CW - PW));
    end else begin
      result_c = PW'(acc_next);
    end
  end

  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign vec_end   = in_last || last_beat;
  assign beat_fire = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ACC;
      acc        <= '0;
      beat_cnt   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_error  <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          in_ready <= 1'b1;
          if (beat_fire) begin
            if (vec_end) begin
              state      <= OUT;
              in_ready   <= 1'b0;
              out_valid  <= 1'b1;
              out_result <= result_c;
              // Framing error: in_last early, or missing on the final beat.
              out_error  <= in_last ^ last_beat;
              acc        <= '0;
              beat_cnt   <= '0;
            end else begin
              acc      <= acc_next;
              beat_cnt <= beat_cnt + BW'(1);
            end
          end
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/lwe_decrypt_seq.md
# lwe_decrypt_seq

Sequential, parametrised LWE decryption core: streams secret-key and ciphertext coefficients LANES at a time, accumulates the dot product mod 2^CIPHERTEXT_WIDTH, then maps the accumulator to a plaintext by rounding or legacy low-bit extraction. It is the successor to the combinational single-vector decryptor and sits between the ciphertext/key fetch path and the plaintext output queue, with valid/ready handshakes on both sides.

## Interface
- PLAINTEXT_WIDTH, 6, plaintext bits; plaintext modulus = 2^PLAINTEXT_WIDTH; must be < CIPHERTEXT_WIDTH
- CIPHERTEXT_WIDTH, 10, coefficient bits; ciphertext modulus = 2^CIPHERTEXT_WIDTH
- DIMENSION, 1, LWE dimension; vectors hold DIMENSION+1 coefficients (index 0..DIMENSION)
- LANES, 1, coefficients per beat; must divide DIMENSION+1; BEATS = (DIMENSION+1)/LANES
- ROUND_MODE, 1, 1 = round-to-nearest top bits; 0 = legacy low-bit extraction
- clk  input  1  clock
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- in_valid  input  1  beat valid
- in_ready  output  1  block accepts a beat
- in_sk  input  LANES*CIPHERTEXT_WIDTH  key coefficients; lane k in bits [k*CW +: CW]
- in_ct  input  LANES*CIPHERTEXT_WIDTH  ciphertext coefficients, same packing
- in_last  input  1  marks final beat of a vector
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  PLAINTEXT_WIDTH  decrypted plaintext
- out_error  output  1  framing error on this vector (in_last misplaced)

## Operation
- States: ACC, OUT. Reset -> ACC, beat counter 0, accumulator 0.
- ACC: in_ready=1. Beat accepted when in_valid && in_ready. acc_next = (acc + sum over lanes of sk[k]*ct[k]) mod 2^CW; products full 2*CW bits, only low CW bits of the sum retained.
- Vector ends on accepted beat with in_last=1 or beat counter = BEATS-1, whichever first. On end: register out_result from acc_next, out_error, go OUT; clear acc and counter.
- out_error=1 if in_last on beat < BEATS-1 (early end, partial sum used) or in_last=0 on beat BEATS-1 (vector still closes).
- ROUND_MODE=1: r = (acc_next + 2^(CW-PW-1)) mod 2^CW; out_result = r[CW-1:CW-PW]. Wrap past 2^CW gives 0 (mod-p correct).
- ROUND_MODE=0: out_result = acc_next[PW-1:0].
- OUT: in_ready=0; out_valid=1; out_result/out_error held stable until out_ready. On out_valid && out_ready -> ACC.

## Timing
- Reset values: out_valid 0, out_result 0, out_error 0, state ACC, acc 0, counter 0. in_ready=0 while rst_n=0; 1 in first cycle after release.
- Final beat accepted at edge t -> out_valid=1 from t (registered on that edge), visible cycle after t.
- in_ready deasserts in same cycle out_valid asserts; no beat accepted while OUT.
- Throughput: BEATS+1 cycles per vector with out_ready=1 and in_valid=1 continuous.
- in_valid low mid-vector: acc and counter hold; no timeout.
- rst_n low mid-vector or in OUT: partial sum and pending result discarded, outputs to reset values on next edge.
- Single multiply-accumulate stage; combinational path is LANES multipliers + adder tree + rounding adder.

## Test plan
- Basic, defaults: sk=(1,3), ct=(100,200), in_last on beat 1 -> acc 700; out_result=44, out_error=0; with ROUND_MODE=0 out_result=60.
- Modular wrap: sk=(1023,1023), ct=(1023,1023) -> acc 2; out_result=0 (ROUND_MODE=1), 2 (ROUND_MODE=0).
- Rounding wrap: sk=(1,0), ct=(1020,5) -> acc 1020, r=4; out_result=0.
- Backpressure: basic vector with out_ready=0 for 3 cycles -> out_valid=1 and out_result=44 held all 3 cycles, in_ready=0, in_valid beats ignored; handshake then in_ready=1 next cycle.
- Framing: sk=(1,x), ct=(100,x), in_last on beat 0 -> out_result=6, out_error=1; basic vector without in_last -> out_result=44, out_error=1; next clean vector out_error=0.
- Reset mid-vector and LANES=2 (DIMENSION=3): assert rst_n=0 after beat 0 -> out_valid=0, in_ready=1 after release; then sk=(1,3,0,0), ct=(100,200,7,9) in 2 beats -> out_result=44.
